// File: rtl/synctimer_adjust_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : synctimer_adjust_arbiter_if
// Brief    : Adjust-pulse bus between the adjust sources, the arbiter and
//            the synchronous timer adjust port.
// Revision : 1.0 - initial release
// ============================================================================
interface synctimer_adjust_arbiter_if #(
  parameter int NUM   = 2,
  parameter int SRC_W = (NUM > 1) ? $clog2(NUM) : 1
);
  logic [NUM-1:0]   s_sign;
  logic [NUM-1:0]   s_valid;
  logic [NUM-1:0]   s_ready;
  logic             m_sign;
  logic             m_valid;
  logic             m_ready;
  logic [SRC_W-1:0] m_source;

  // Environment side: drives the source pulses and the timer ready.
  modport master (
    output s_sign, s_valid, m_ready,
    input  s_ready, m_sign, m_valid, m_source
  );

  // Arbiter side.
  modport slave (
    input  s_sign, s_valid, m_ready,
    output s_ready, m_sign, m_valid, m_source
  );
endinterface
`default_nettype wire

// File: rtl/synctimer_adjust_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : synctimer_adjust_arbiter
// Brief    : Banks single-step adjust pulses from NUM sources in signed
//            pending counters and drains them round-robin onto the single
//            timer adjust port.
// Revision : 1.0 - initial release
// ============================================================================
module synctimer_adjust_arbiter #(
  parameter int NUM         = 2,
  parameter int COUNT_WIDTH = 8
) (
  input  wire logic                clk,
  input  wire logic                reset,
  synctimer_adjust_arbiter_if.slave bus
);

  localparam int SRC_W = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int CW    = COUNT_WIDTH;

  localparam logic signed [CW-1:0] c_zero      = '0;
  localparam logic signed [CW-1:0] c_one       = {{(CW-1){1'b0}}, 1'b1};
  localparam logic signed [CW-1:0] c_minus_one = '1;
  localparam logic signed [CW-1:0] c_max       = {1'b0, {(CW-1){1'b1}}};
  localparam logic signed [CW-1:0] c_neg_max   = c_zero - c_max;

  logic signed [CW-1:0] r_cnt [NUM];
  logic signed [CW-1:0] w_inc [NUM];
  logic signed [CW-1:0] w_dec [NUM];
  logic [NUM-1:0]       w_ready;
  logic [NUM-1:0]       w_accept;

  logic                 r_m_valid;
  logic                 r_m_sign;
  logic [SRC_W-1:0]     r_m_source;
  logic [SRC_W-1:0]     r_last;

  logic                 w_slot_free;
  logic                 w_any;
  logic                 w_do_grant;
  logic [SRC_W-1:0]     w_gidx;
  logic [SRC_W:0]       w_sum;

  assign w_slot_free = !r_m_valid || bus.m_ready;
  assign w_do_grant  = w_slot_free && w_any;

  // Per-source accept gating and counter step terms.
  for (genvar gi = 0; gi < NUM; gi++) begin : g_src
    // Block only the direction that would push the counter past its limit.
    assign w_ready[gi]  = bus.s_sign[gi] ? (r_cnt[gi] != c_neg_max)
                                         : (r_cnt[gi] != c_max);
    assign w_accept[gi] = bus.s_valid[gi] && w_ready[gi];
    assign w_inc[gi]    = !w_accept[gi]  ? c_zero
                        : (bus.s_sign[gi] ? c_minus_one : c_one);
    // A granted counter moves one step toward zero.
    assign w_dec[gi]    = !(w_do_grant && (w_gidx == SRC_W'(gi))) ? c_zero
                        : (r_cnt[gi][CW-1] ? c_one : c_minus_one);
  end

  // Round-robin search for the first nonzero counter after the last grant.
  always_comb begin
    w_any  = 1'b0;
    w_gidx = '0;
    w_sum  = '0;
    for (int k = 1; k <= NUM; k++) begin
      w_sum = {1'b0, r_last} + (SRC_W+1)'(k);
      if (w_sum >= (SRC_W+1)'(NUM)) begin
        w_sum = w_sum - (SRC_W+1)'(NUM);
      end
      if (!w_any && (r_cnt[w_sum[SRC_W-1:0]] != c_zero)) begin
        w_any  = 1'b1;
        w_gidx = w_sum[SRC_W-1:0];
      end
    end
  end

  // Pending counters: accept and grant may both land in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM; i++) begin
        r_cnt[i] <= c_zero;
      end
    end else begin
      for (int i = 0; i < NUM; i++) begin
        r_cnt[i] <= r_cnt[i] + w_inc[i] + w_dec[i];
      end
    end
  end

  // Output slot: load on grant, empty when consumed with nothing pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m_valid  <= 1'b0;
      r_m_sign   <= 1'b0;
      r_m_source <= '0;
      r_last     <= SRC_W'(NUM - 1);
    end else if (w_do_grant) begin
      r_m_valid  <= 1'b1;
      r_m_sign   <= r_cnt[w_gidx][CW-1];
      r_m_source <= w_gidx;
      r_last     <= w_gidx;
    end else if (w_slot_free) begin
      r_m_valid  <= 1'b0;
    end
  end

  assign bus.s_ready  = w_ready;
  assign bus.m_valid  = r_m_valid;
  assign bus.m_sign   = r_m_sign;
  assign bus.m_source = r_m_source;

endmodule
`default_nettype wire

// File: tb/tb_synctimer_adjust_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_synctimer_adjust_arbiter
// Brief    : Directed bench for synctimer_adjust_arbiter (NUM=2, 4-bit
//            counters) with an output-pulse scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_synctimer_adjust_arbiter;

  localparam int NUM = 2;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   n_acc;

  // Expected output pulses as {source, sign}, in emission order.
  logic [1:0] exp_q [$];
  logic [1:0] exp_v;

  synctimer_adjust_arbiter_if #(.NUM(NUM)) bus ();

  synctimer_adjust_arbiter #(.NUM(NUM), .COUNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int src, input logic sgn);
    bus.s_sign[src]  = sgn;
    bus.s_valid[src] = 1'b1;
    tick();
    bus.s_valid[src] = 1'b0;
  endtask

  task automatic drain(input string tag, input int n);
    repeat (n) tick();
    check({tag, "_idle"}, 8'(bus.m_valid), 8'd0);
    check({tag, "_queue_empty"}, 8'(exp_q.size()), 8'd0);
  endtask

  // Scoreboard: every pulse the timer takes must be the next expected one.
  always @(negedge clk) begin
    if (!reset && bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL spurious_pulse: observed src=%0d sign=%0d expected none",
               bus.m_source, bus.m_sign);
      end
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        check("pulse", 8'({bus.m_source, bus.m_sign}), 8'(exp_v));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    bus.s_valid = '0;
    bus.s_sign  = '0;
    bus.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", 8'(bus.m_valid), 8'd0);
    check("rst_m_sign", 8'(bus.m_sign), 8'd0);
    check("rst_m_source", 8'(bus.m_source), 8'd0);
    reset = 1'b0;
    #1;
    check("rst_s_ready", 8'(bus.s_ready), 8'd3);

    // Single source, three back-to-back positive pulses.
    bus.m_ready    = 1'b1;
    bus.s_sign[0]  = 1'b0;
    bus.s_valid[0] = 1'b1;
    repeat (3) exp_q.push_back(2'b00);
    tick();
    check("t1_latency_low", 8'(bus.m_valid), 8'd0);
    tick();
    check("t1_latency_high", 8'(bus.m_valid), 8'd1);
    check("t1_source", 8'(bus.m_source), 8'd0);
    tick();
    bus.s_valid[0] = 1'b0;
    drain("t1", 6);

    // Cancellation inside source 1: net +1 gives exactly one pulse.
    bus.m_ready = 1'b0;
    pulse(1, 1'b0);
    pulse(1, 1'b0);
    pulse(1, 1'b1);
    pulse(1, 1'b0);
    pulse(1, 1'b1);
    exp_q.push_back(2'b10);
    check("t2_held_valid", 8'(bus.m_valid), 8'd1);
    check("t2_held_source", 8'(bus.m_source), 8'd1);
    bus.m_ready = 1'b1;
    drain("t2", 6);

    // Round-robin between +2 on source 0 and -2 on source 1.
    bus.m_ready = 1'b0;
    bus.s_sign  = 2'b10;
    bus.s_valid = 2'b11;
    tick();
    tick();
    bus.s_valid = 2'b00;
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b11);
    bus.m_ready = 1'b1;
    drain("t3", 8);

    // Saturation at +7 with the output slot held busy.
    bus.m_ready = 1'b0;
    pulse(1, 1'b0);
    exp_q.push_back(2'b10);
    tick();
    check("t4_slot_busy", 8'(bus.m_valid), 8'd1);
    n_acc = 0;
    bus.s_sign[0]  = 1'b0;
    bus.s_valid[0] = 1'b1;
    #1;
    for (int k = 0; k < 20 && bus.s_ready[0]; k++) begin
      n_acc++;
      tick();
    end
    check("t4_accepts", 8'(n_acc), 8'd7);
    check("t4_ready_low", 8'(bus.s_ready[0]), 8'd0);
    bus.s_sign[0] = 1'b1;
    #1;
    check("t4_neg_ready", 8'(bus.s_ready[0]), 8'd1);
    tick();
    bus.s_sign[0] = 1'b0;
    #1;
    check("t4_ready_at_6", 8'(bus.s_ready[0]), 8'd1);
    tick();
    check("t4_ready_low_again", 8'(bus.s_ready[0]), 8'd0);
    repeat (7) exp_q.push_back(2'b00);
    bus.m_ready = 1'b1;
    tick();
    check("t4_ready_after_drain", 8'(bus.s_ready[0]), 8'd1);
    bus.s_valid[0] = 1'b0;
    drain("t4", 12);

    // Accept and grant on the same source in the same cycle.
    bus.m_ready = 1'b0;
    pulse(0, 1'b0);
    tick();
    pulse(0, 1'b0);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b01);
    bus.m_ready    = 1'b1;
    bus.s_sign[0]  = 1'b1;
    bus.s_valid[0] = 1'b1;
    tick();
    bus.s_valid[0] = 1'b0;
    check("t5_valid", 8'(bus.m_valid), 8'd1);
    check("t5_sign_pos", 8'(bus.m_sign), 8'd0);
    check("t5_source", 8'(bus.m_source), 8'd0);
    tick();
    check("t5_sign_neg", 8'(bus.m_sign), 8'd1);
    drain("t5", 4);

    // Asynchronous reset in the middle of a burst.
    bus.m_ready    = 1'b0;
    bus.s_sign[0]  = 1'b0;
    bus.s_valid[0] = 1'b1;
    repeat (6) tick();
    bus.s_valid[0] = 1'b0;
    check("t6_busy", 8'(bus.m_valid), 8'd1);
    #2 reset = 1'b1;
    #1;
    check("t6_async_drop", 8'(bus.m_valid), 8'd0);
    exp_q.delete();
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    bus.m_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t6_no_pulse", 8'(bus.m_valid), 8'd0);
    end
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b10);
    bus.s_sign  = 2'b00;
    bus.s_valid = 2'b11;
    tick();
    bus.s_valid = 2'b00;
    tick();
    check("t6_first_src0", 8'(bus.m_source), 8'd0);
    tick();
    check("t6_then_src1", 8'(bus.m_source), 8'd1);
    drain("t6", 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
